// File: rtl/load_extend_unit.sv
// load_extend_unit: registered load-data aligner with zero/sign extension.
// Selects the addressed byte/half/word/double from a little-endian memory
// word, extends it to full width and holds it in a single output register
// behind a valid/ready handshake. Misaligned or oversized accesses produce
// a zeroed result with a fault flag and bump a saturating fault counter.
module load_extend_unit #(
  parameter int DATA_WIDTH = 32,
  localparam int OFFSET_WIDTH = $clog2(DATA_WIDTH / 8),
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [OFFSET_WIDTH-1:0]  in_offset,
  input  logic [1:0]               in_size,
  input  logic                     in_sign_ext,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_fault,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  logic                  accept;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] field_mask;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [DATA_WIDTH-1:0] data_next;
  logic [6:0]            size_bits;
  logic [3:0]            lane_mask;
  logic                  sign_bit;
  logic                  illegal_size;
  logic                  misaligned;
  logic                  fault;

  // The register can take a new request whenever it is empty or draining.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Align the addressed lane to bit 0, mask to the access width and extend.
  always_comb begin
    shifted    = in_data >> {in_offset, 3'b000};
    size_bits  = 7'd8 << in_size;
    // Shifting all-ones by the access width leaves ones only above the field;
    // for a full-width access the shift clears everything, so the mask is all ones.
    field_mask = ~({DATA_WIDTH{1'b1}} << size_bits);
    case (in_size)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_WIDTH-1];
    endcase
    ext_data = shifted & field_mask;
    if (in_sign_ext && sign_bit) begin
      ext_data = ext_data | ~field_mask;
    end
    // A double access only exists on a 64-bit datapath.
    illegal_size = (DATA_WIDTH < 64) && (in_size == 2'd3);
    lane_mask    = (4'd1 << in_size) - 4'd1;
    misaligned   = |(in_offset & lane_mask[OFFSET_WIDTH-1:0]);
    fault        = illegal_size || misaligned;
    data_next    = fault ? '0 : ext_data;
  end

  // Output register with bubble collapse; the fault counter advances on the load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_fault <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= data_next;
        out_fault <= fault;
        if (fault && (err_count != {ERR_CNT_WIDTH{1'b1}})) begin
          err_count <= err_count + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
// Testbench for load_extend_unit: directed vectors, fault saturation,
// backpressure, streaming and a randomized scoreboard run on a 32-bit
// instance, plus directed and random checks on a 64-bit instance.
module tb_load_extend_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // 32-bit instance
  logic        in_valid, in_ready, in_sign_ext, out_valid, out_ready, out_fault;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_offset, in_size;
  logic [7:0]  err_count;
  // 64-bit instance
  logic        w_in_valid, w_in_ready, w_in_sign_ext, w_out_valid, w_out_ready, w_out_fault;
  logic [63:0] w_in_data, w_out_data;
  logic [2:0]  w_in_offset;
  logic [1:0]  w_in_size;
  logic [7:0]  w_err_count;

  int errors = 0;
  int checks = 0;
  int exp_ec = 0;

  load_extend_unit #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_offset(in_offset), .in_size(in_size), .in_sign_ext(in_sign_ext),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_fault(out_fault), .err_count(err_count)
  );

  load_extend_unit #(.DATA_WIDTH(64), .ERR_CNT_WIDTH(8)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_offset(w_in_offset), .in_size(w_in_size), .in_sign_ext(w_in_sign_ext),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_fault(w_out_fault), .err_count(w_err_count)
  );

  // Reference: pick the field arithmetically and add the sign fill as a constant.
  function automatic logic [63:0] ref_load(input int dw, input logic [63:0] d, input int off,
                                           input int size, input bit sx, output bit flt);
    int bits;
    longint unsigned field, all_dw, res;
    bits = 8 << size;
    flt  = (bits > dw) || ((off % (1 << size)) != 0);
    if (flt) return 64'd0;
    field = d >> (off * 8);
    if (bits < 64) field = field % (64'd1 << bits);
    all_dw = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 1);
    res = field;
    if (sx && bits < dw && ((field >> (bits - 1)) & 1) == 1)
      res = field + all_dw - ((64'd1 << bits) - 1);
    return res;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic drive32(input logic [31:0] d, input logic [1:0] o, input logic [1:0] s, input logic x);
    in_valid = 1'b1; in_data = d; in_offset = o; in_size = s; in_sign_ext = x;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_ec = 0;
  endtask

  // Random faulting request: misaligned half/word or an illegal double.
  task automatic drive_fault32();
    int r;
    logic [1:0] o;
    r = $urandom % 3;
    o = 2'($urandom);
    if (r == 0)      drive32($urandom, o | 2'd1, 2'd1, 1'($urandom));
    else if (r == 1) drive32($urandom, (o == 2'd0) ? 2'd2 : o, 2'd2, 1'($urandom));
    else             drive32($urandom, o, 2'd3, 1'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; w_out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_in_offset = '0; w_in_size = '0; w_in_sign_ext = 1'b0;
    drive32(32'hFFFF_FF80, 2'd0, 2'd0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset out_data: got %h want 0", out_data); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL reset out_fault: got %b want 0", out_fault); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset err_count: got %0d want 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset dropped_req: out_valid got %b want 0", out_valid); end
    $display("reset: out_valid=%b out_data=%h err_count=%0d", out_valid, out_data, err_count);
  endtask

  task automatic test_lanes();
    logic [1:0]  offs [5];
    logic [1:0]  sizes [5];
    logic        sxs [5];
    logic [31:0] want [5];
    offs  = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
    sizes = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    sxs   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    want  = '{32'hFFFF_FFA1, 32'h0000_00A1, 32'h0000_0065, 32'hFFFF_8765, 32'h0000_43A1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive32(32'h8765_43A1, offs[i], sizes[i], sxs[i]);
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lane_%0d out_valid: got %b want 1", i, out_valid); end
      checks++; if (out_data !== want[i]) begin errors++; $display("FAIL lane_%0d out_data: got %h want %h", i, out_data, want[i]); end
      checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL lane_%0d out_fault: got %b want 0", i, out_fault); end
      $display("lane off=%0d size=%0d sx=%b -> %h", offs[i], sizes[i], sxs[i], out_data);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0000_43A1) begin errors++; $display("FAIL idle hold out_data: got %h want 000043a1", out_data); end
  endtask

  task automatic test_fault();
    logic [1:0] offs [3];
    logic [1:0] sizes [3];
    logic       sxs [3];
    offs  = '{2'd1, 2'd0, 2'd2};
    sizes = '{2'd1, 2'd3, 2'd2};
    sxs   = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive32(32'h8765_43A1, offs[i], sizes[i], sxs[i]);
      @(negedge clk); in_valid = 1'b0;
      exp_ec = sat_inc(exp_ec);
      checks++; if (out_fault !== 1'b1) begin errors++; $display("FAIL fault_%0d out_fault: got %b want 1", i, out_fault); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL fault_%0d out_data: got %h want 0", i, out_data); end
      checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL fault_%0d err_count: got %0d want %0d", i, err_count, exp_ec); end
      $display("fault off=%0d size=%0d -> fault=%b err_count=%0d", offs[i], sizes[i], out_fault, err_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_ec = sat_inc(exp_ec);
        checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL sat_%0d err_count: got %0d want %0d", i, err_count, exp_ec); end
      end
      drive_fault32();
    end
    @(negedge clk); in_valid = 1'b0;
    exp_ec = sat_inc(exp_ec);
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_final err_count: got %0d want 255", err_count); end
    $display("saturation: err_count=%0d after 300+ faults", err_count);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_fault32();
    end
    @(negedge clk); drive32(32'h1234_5678, 2'd0, 2'd2, 1'b0); out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL mid err_count: got %0d want 3", err_count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid out_valid: got %b want 1", out_valid); end
    rst = 1'b1; drive32(32'h8765_43A1, 2'd1, 2'd1, 1'b1);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_ec = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rstmid err_count: got %0d want 0", err_count); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rstmid out_data: got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid in_ready: got %b want 1", in_ready); end
    $display("reset mid-op: out_valid=%b err_count=%0d", out_valid, err_count);
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [63:0] a_exp;
    bit          f;
    a = $urandom;
    a_exp = ref_load(32, {32'd0, a}, 1, 0, 1'b1, f);
    @(negedge clk); out_ready = 1'b0; drive32(a, 2'd1, 2'd0, 1'b1);
    @(negedge clk); drive32(32'hCAFE_F00D, 2'd1, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_%0d in_ready: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_%0d out_valid: got %b want 1", i, out_valid); end
      checks++; if (out_data !== a_exp[31:0]) begin errors++; $display("FAIL stall_%0d out_data: got %h want %h", i, out_data, a_exp[31:0]); end
      checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL stall_%0d out_fault: got %b want 0", i, out_fault); end
      checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL stall_%0d err_count: got %0d want %0d", i, err_count, exp_ec); end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release in_ready: got %b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    exp_ec = sat_inc(exp_ec);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL swap out_valid: got %b want 1", out_valid); end
    checks++; if (out_fault !== 1'b1 || out_data !== 32'd0) begin errors++; $display("FAIL swap result: got fault=%b data=%h want fault=1 data=0", out_fault, out_data); end
    checks++; if (err_count !== 8'(exp_ec)) begin errors++; $display("FAIL swap err_count: got %0d want %0d", err_count, exp_ec); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain out_valid: got %b want 0", out_valid); end
    $display("backpressure: held %h for 5 cycles, then swapped in faulting request", a_exp[31:0]);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q_data [$];
    logic [63:0] r;
    logic [31:0] exp_d, d;
    logic [1:0]  s, o;
    logic        x;
    bit          f;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_d = q_data.pop_front();
        checks++; if (out_valid !== 1'b1 || out_fault !== 1'b0) begin errors++; $display("FAIL b2b_%0d status: got valid=%b fault=%b want 1/0", i - 1, out_valid, out_fault); end
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL b2b_%0d out_data: got %h want %h", i - 1, out_data, exp_d); end
        $display("b2b %0d: %h", i - 1, out_data);
      end
      if (i < 16) begin
        d = $urandom; s = 2'($urandom_range(0, 2)); x = 1'($urandom);
        o = 2'($urandom) & ~2'((1 << s) - 1);
        r = ref_load(32, {32'd0, d}, int'(o), int'(s), x, f);
        q_data.push_back(r[31:0]);
        drive32(d, o, s, x);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    bit          m_valid, m_fault, f, exp_rdy;
    logic [31:0] m_data;
    logic [63:0] r;
    do_reset();
    m_valid = 1'b0; m_fault = 1'b0; m_data = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_fault !== m_fault || err_count !== 8'(exp_ec)) begin
        errors++;
        $display("FAIL rand_%0d outputs: got v=%b d=%h f=%b ec=%0d want v=%b d=%h f=%b ec=%0d",
                 i, out_valid, out_data, out_fault, err_count, m_valid, m_data, m_fault, exp_ec);
      end
      drive32($urandom, 2'($urandom), 2'($urandom), 1'($urandom));
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      #1;
      exp_rdy = !m_valid || out_ready;
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_%0d in_ready: got %b want %b", i, in_ready, exp_rdy); end
      if (in_valid && exp_rdy) begin
        r = ref_load(32, {32'd0, in_data}, int'(in_offset), int'(in_size), in_sign_ext, f);
        m_valid = 1'b1; m_data = r[31:0]; m_fault = f;
        if (f) exp_ec = sat_inc(exp_ec);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    $display("random: 80 cycles done, err_count=%0d", err_count);
  endtask

  task automatic test_dw64();
    logic [63:0] d, r;
    bit          f;
    int          w_ec;
    w_ec = 0;
    @(negedge clk);
    w_in_valid = 1'b1; w_in_data = 64'h8000_0000_0000_0001; w_in_offset = 3'd4; w_in_size = 2'd2; w_in_sign_ext = 1'b1;
    @(negedge clk);
    checks++; if (w_out_valid !== 1'b1 || w_out_data !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL dw64_word: got v=%b %h want 1 ffffffff80000000", w_out_valid, w_out_data); end
    $display("dw64 word off4: %h", w_out_data);
    w_in_offset = 3'd0; w_in_size = 2'd3;
    @(negedge clk);
    checks++; if (w_out_data !== 64'h8000_0000_0000_0001 || w_out_fault !== 1'b0) begin errors++; $display("FAIL dw64_double: got %h f=%b want 8000000000000001 f=0", w_out_data, w_out_fault); end
    $display("dw64 double: %h", w_out_data);
    w_in_offset = 3'd4;
    @(negedge clk);
    w_ec = sat_inc(w_ec);
    checks++; if (w_out_fault !== 1'b1 || w_out_data !== 64'd0 || w_err_count !== 8'(w_ec)) begin errors++; $display("FAIL dw64_misalign: got f=%b d=%h ec=%0d want f=1 d=0 ec=%0d", w_out_fault, w_out_data, w_err_count, w_ec); end
    $display("dw64 misaligned double: fault=%b", w_out_fault);
    for (int i = 0; i < 12; i++) begin
      d = {$urandom, $urandom};
      w_in_data = d; w_in_offset = 3'($urandom); w_in_size = 2'($urandom); w_in_sign_ext = 1'($urandom);
      r = ref_load(64, d, int'(w_in_offset), int'(w_in_size), w_in_sign_ext, f);
      if (f) w_ec = sat_inc(w_ec);
      @(negedge clk);
      checks++;
      if (w_out_data !== r || w_out_fault !== f || w_err_count !== 8'(w_ec)) begin
        errors++;
        $display("FAIL dw64_rand_%0d: got d=%h f=%b ec=%0d want d=%h f=%b ec=%0d", i, w_out_data, w_out_fault, w_err_count, r, f, w_ec);
      end
      $display("dw64 rand %0d: %h fault=%b", i, w_out_data, w_out_fault);
    end
    w_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_fault();
    test_saturation();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_dw64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_extend_unit.md
# load_extend_unit

Registered load-data aligner and zero/sign extender for the memory stage. It takes a raw data-memory word, the byte offset, the access size and a signed/unsigned mode. It selects the addressed byte, halfword or word, extends it to full width and presents it with a valid/ready handshake, one cycle later. Misaligned or illegal accesses raise a fault flag and increment a saturating fault counter for the exception logic.

## Interface
- DATA_WIDTH, 32, datapath width in bits; legal values 32 or 64.
- OFFSET_WIDTH, log2(DATA_WIDTH/8), byte-offset width; derived, not overridden.
- ERR_CNT_WIDTH, 8, width of the saturating fault counter.

Clock and reset: one clock; reset is synchronous and active-high.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- in_data  input  DATA_WIDTH  raw memory word, little-endian byte lanes (byte k = bits 8k+7:8k).
- in_offset  input  OFFSET_WIDTH  byte address within the word.
- in_size  input  2  access width is 8<<in_size bits (0 = byte, 1 = half, 2 = word, 3 = double).
- in_sign_ext  input  1  1 = sign extend, 0 = zero extend.
- out_valid  output  1  result register holds a transaction.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_WIDTH  extended result.
- out_fault  output  1  the transaction in the register was misaligned or illegal.
- err_count  output  ERR_CNT_WIDTH  number of faulted transactions accepted, saturating.

## Operation
- Accept: a request is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready, which is combinational from out_valid and out_ready.
- Lane select: field = in_data[in_offset*8 +: (8<<in_size)].
- Extension:
  - If in_sign_ext = 1, the field's MSB fills the upper DATA_WIDTH-(8<<in_size) bits.
  - Otherwise the upper bits are 0.
  - A full-width access passes in_data through unchanged.
- Fault conditions:
  - (8<<in_size) > DATA_WIDTH, e.g. in_size = 3 when DATA_WIDTH = 32.
  - in_offset is not a multiple of (1<<in_size).
- On a fault: out_data is all zeros, out_fault = 1, and err_count increments by 1 unless it is already all ones.
- The fault check is independent of in_sign_ext.
- Output register:
  - On accept, out_data, out_fault and out_valid = 1 load together.
  - If out_valid && out_ready and there is no accept in the same cycle, out_valid clears.
  - out_data and out_fault hold their last values while out_valid = 0.
- Stall: while out_valid && !out_ready, all outputs hold bit-for-bit stable and in_ready = 0.
- There is no internal state machine beyond the valid bit; the block is a single pipeline register with a backpressure bubble-collapse.

## Timing
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: one transaction per cycle while out_ready = 1.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the new transaction replaces the old one in the same edge, and out_valid stays 1.
- Reset values: out_valid = 0, out_data = 0, out_fault = 0, err_count = 0; in_ready = 1 in the first cycle after reset.
- Reset wins over everything. A request presented during rst = 1 is dropped, and a held result is discarded.
- err_count updates on the same edge that loads the faulting transaction, not when it drains.

## Test plan
- Byte lane, sign extend:
  - DATA_WIDTH = 32, in_data = 0x876543A1, offset 0, size 0, sign_ext 1 -> next cycle out_valid = 1, out_data = 0xFFFFFFA1, out_fault = 0.
  - Same with sign_ext 0 -> 0x000000A1.
  - Same with offset 2, sign_ext 1 -> 0x00000065.
- Halfword:
  - Offset 2, size 1, sign_ext 1 -> 0xFFFF8765.
  - Offset 0, sign_ext 1 -> 0x000043A1.
- Fault:
  - Offset 1, size 1 -> out_fault = 1, out_data = 0, err_count 0 -> 1.
  - Size 3 at DATA_WIDTH = 32 -> out_fault = 1.
  - 300 faulting accepts -> err_count saturates at 255.
- Backpressure:
  - out_ready = 0 after the first accept -> in_ready = 0 and outputs stable for 5 cycles, and a second request is not consumed.
  - Release out_ready -> the first result drains and the second loads on the same edge, with out_valid continuously 1.
- Back-to-back streaming with out_ready = 1: 16 random legal requests -> 16 results in order, one per cycle, matching a reference model.
- Reset mid-operation:
  - Assert rst while out_valid = 1 and err_count = 3 -> next cycle out_valid = 0, err_count = 0, out_data = 0, in_ready = 1.
- DATA_WIDTH = 64:
  - 0x80000000_00000001, size 2, offset 4, sign_ext 1 -> 0xFFFFFFFF_80000000.
  - Size 3, offset 0 -> passthrough.
